// File: rtl/sc_collision_pkg.sv
// -----------------------------------------------------------------------------
// sc_collision_pkg
// Purpose : Shared game-rule constants for the collision/lives stage and the
//           lane registers that consume its ESTADO/NVL outputs.
// Contents: ESTADO state codes, the matching state enum, frog row constants
//           and a row-classification helper.
// -----------------------------------------------------------------------------
package sc_collision_pkg;

   localparam int ESTADO_W = 3;

   // State codes as seen on the ESTADO bus
   localparam logic [ESTADO_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [ESTADO_W-1:0] ST_PLAY     = 3'd1;
   localparam logic [ESTADO_W-1:0] ST_RESPAWN  = 3'd2;
   localparam logic [ESTADO_W-1:0] ST_GAMEOVER = 3'd3;

   typedef enum logic [ESTADO_W-1:0] {
      S_IDLE     = ST_IDLE,
      S_PLAY     = ST_PLAY,
      S_RESPAWN  = ST_RESPAWN,
      S_GAMEOVER = ST_GAMEOVER
   } state_t;

   // Frog row encoding
   localparam logic [2:0] ROW_START      = 3'd0;
   localparam logic [2:0] ROW_LANE_FIRST = 3'd1;
   localparam logic [2:0] ROW_GOAL       = 3'd5;

   // True when the row sits over one of the four vehicle lanes
   function automatic logic is_lane_row(input logic [2:0] row);
      return (row >= ROW_LANE_FIRST) && (row < ROW_GOAL);
   endfunction

endpackage

// File: rtl/sc_collision_overlap.sv
// -----------------------------------------------------------------------------
// sc_collision_overlap
// Purpose : Combinational frog/vehicle overlap detect. Selects the lane bus
//           under the frog's row and picks the bit at the frog's column.
// Ports   : i_lane0..i_lane3 - lane occupancy for rows 1..4 (bit c = column c)
//           i_row, i_col     - frog position
//           o_overlap        - 1 when the frog shares a cell with a vehicle
// -----------------------------------------------------------------------------
module sc_collision_overlap
   import sc_collision_pkg::*;
#(
   parameter int DATAWIDTH_BUS = 8
) (
   input  logic [DATAWIDTH_BUS-1:0] i_lane0,
   input  logic [DATAWIDTH_BUS-1:0] i_lane1,
   input  logic [DATAWIDTH_BUS-1:0] i_lane2,
   input  logic [DATAWIDTH_BUS-1:0] i_lane3,
   input  logic [2:0]               i_row,
   input  logic [2:0]               i_col,
   output logic                     o_overlap
);

   logic [DATAWIDTH_BUS-1:0] w_lane;

   // Lane select by row; start, goal and safe rows see an empty lane
   always_comb begin
      w_lane = '0;
      case (i_row)
         ROW_LANE_FIRST:         w_lane = i_lane0;
         ROW_LANE_FIRST + 3'd1:  w_lane = i_lane1;
         ROW_LANE_FIRST + 3'd2:  w_lane = i_lane2;
         ROW_LANE_FIRST + 3'd3:  w_lane = i_lane3;
         default:                w_lane = '0;
      endcase
      if (is_lane_row(i_row)) begin
         o_overlap = w_lane[i_col];
      end else begin
         o_overlap = 1'b0;
      end
   end

endmodule

// File: rtl/sc_collision_lives.sv
// -----------------------------------------------------------------------------
// sc_collision_lives
// Purpose : Game-rule stage behind the lane registers. Debounces frog/vehicle
//           overlap into hits, detects goal arrival, tracks lives and level,
//           and runs the IDLE/PLAY/RESPAWN/GAMEOVER game FSM.
// Ports   : SC_COLLISION_CLOCK_50      - 50 MHz game clock
//           SC_COLLISION_RESET         - synchronous active-high reset
//           SC_COLLISION_START_IN      - start/restart (IDLE, GAMEOVER only)
//           SC_COLLISION_LANE0..3_IN   - lane occupancy, rows 1..4
//           SC_COLLISION_FROG_ROW/COL  - frog position
//           SC_COLLISION_HIT_OUT       - one-cycle hit pulse
//           SC_COLLISION_GOAL_OUT      - one-cycle goal pulse
//           SC_COLLISION_RESPAWN_OUT   - high for the whole respawn window
//           SC_COLLISION_LIVES_OUT     - remaining lives
//           SC_COLLISION_NVL_OUT       - level (to lane registers)
//           SC_COLLISION_ESTADO_OUT    - state code (to lane registers)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sc_collision_lives
   import sc_collision_pkg::*;
#(
   parameter int DATAWIDTH_BUS    = 8,
   parameter int DATAWIDTH_NIVEL  = 2,
   parameter int DATAWIDTH_ESTADO = 3,
   parameter int DATAWIDTH_LIVES  = 2,
   parameter int LIVES_INIT       = 3,
   parameter int HIT_HOLD         = 2,
   parameter int RESPAWN_CYCLES   = 16
) (
   input  logic                        SC_COLLISION_CLOCK_50,
   input  logic                        SC_COLLISION_RESET,
   input  logic                        SC_COLLISION_START_IN,
   input  logic [DATAWIDTH_BUS-1:0]    SC_COLLISION_LANE0_IN,
   input  logic [DATAWIDTH_BUS-1:0]    SC_COLLISION_LANE1_IN,
   input  logic [DATAWIDTH_BUS-1:0]    SC_COLLISION_LANE2_IN,
   input  logic [DATAWIDTH_BUS-1:0]    SC_COLLISION_LANE3_IN,
   input  logic [2:0]                  SC_COLLISION_FROG_ROW_IN,
   input  logic [2:0]                  SC_COLLISION_FROG_COL_IN,
   output logic                        SC_COLLISION_HIT_OUT,
   output logic                        SC_COLLISION_GOAL_OUT,
   output logic                        SC_COLLISION_RESPAWN_OUT,
   output logic [DATAWIDTH_LIVES-1:0]  SC_COLLISION_LIVES_OUT,
   output logic [DATAWIDTH_NIVEL-1:0]  SC_COLLISION_NVL_OUT,
   output logic [DATAWIDTH_ESTADO-1:0] SC_COLLISION_ESTADO_OUT
);

   localparam int HOLD_W = $clog2(HIT_HOLD + 1);
   localparam int RESP_W = $clog2(RESPAWN_CYCLES + 1);

   localparam logic [HOLD_W-1:0]          HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]          HOLD_LAST  = HOLD_W'(HIT_HOLD - 1);
   localparam logic [RESP_W-1:0]          RESP_ONE   = RESP_W'(1);
   localparam logic [RESP_W-1:0]          RESP_LAST  = RESP_W'(RESPAWN_CYCLES - 1);
   localparam logic [DATAWIDTH_LIVES-1:0] LIVES_ONE  = DATAWIDTH_LIVES'(1);
   localparam logic [DATAWIDTH_LIVES-1:0] LIVES_LOAD = DATAWIDTH_LIVES'(LIVES_INIT);
   localparam logic [DATAWIDTH_NIVEL-1:0] NVL_ONE    = DATAWIDTH_NIVEL'(1);
   localparam logic [DATAWIDTH_NIVEL-1:0] NVL_MAX    = {DATAWIDTH_NIVEL{1'b1}};

   state_t                       r_state;
   logic [HOLD_W-1:0]            r_hold;
   logic [RESP_W-1:0]            r_resp;
   logic                         r_hit;
   logic                         r_goal;
   logic                         r_respawn;
   logic [DATAWIDTH_LIVES-1:0]   r_lives;
   logic [DATAWIDTH_NIVEL-1:0]   r_nvl;

   logic                         w_overlap;
   logic                         w_hold_done;
   logic                         w_resp_done;
   logic                         w_last_life;

   sc_collision_overlap #(
      .DATAWIDTH_BUS (DATAWIDTH_BUS)
   ) u_overlap (
      .i_lane0   (SC_COLLISION_LANE0_IN),
      .i_lane1   (SC_COLLISION_LANE1_IN),
      .i_lane2   (SC_COLLISION_LANE2_IN),
      .i_lane3   (SC_COLLISION_LANE3_IN),
      .i_row     (SC_COLLISION_FROG_ROW_IN),
      .i_col     (SC_COLLISION_FROG_COL_IN),
      .o_overlap (w_overlap)
   );

   assign w_hold_done = (r_hold == HOLD_LAST);
   assign w_resp_done = (r_resp == RESP_LAST);
   // Treat 0 like 1 so a hit can never wrap the lives counter
   assign w_last_life = (r_lives <= LIVES_ONE);

   // Game FSM, debounce/respawn counters and all registered outputs
   always_ff @(posedge SC_COLLISION_CLOCK_50) begin
      if (SC_COLLISION_RESET) begin
         r_state   <= S_IDLE;
         r_hold    <= '0;
         r_resp    <= '0;
         r_hit     <= 1'b0;
         r_goal    <= 1'b0;
         r_respawn <= 1'b0;
         r_lives   <= '0;
         r_nvl     <= '0;
      end else begin
         r_hit  <= 1'b0;
         r_goal <= 1'b0;
         case (r_state)
            S_IDLE, S_GAMEOVER: begin
               if (SC_COLLISION_START_IN) begin
                  r_state <= S_PLAY;
                  r_lives <= LIVES_LOAD;
                  r_nvl   <= '0;
                  r_hold  <= '0;
               end
            end
            S_PLAY: begin
               if (w_overlap) begin
                  if (w_hold_done) begin
                     r_hit  <= 1'b1;
                     r_hold <= '0;
                     r_resp <= '0;
                     if (w_last_life) begin
                        r_lives <= '0;
                        r_state <= S_GAMEOVER;
                     end else begin
                        r_lives   <= r_lives - LIVES_ONE;
                        r_state   <= S_RESPAWN;
                        r_respawn <= 1'b1;
                     end
                  end else begin
                     r_hold <= r_hold + HOLD_ONE;
                  end
               end else begin
                  r_hold <= '0;
                  // Goal row can never overlap, so hit and goal never coincide
                  if (SC_COLLISION_FROG_ROW_IN == ROW_GOAL) begin
                     r_goal    <= 1'b1;
                     r_nvl     <= (r_nvl == NVL_MAX) ? r_nvl : r_nvl + NVL_ONE;
                     r_resp    <= '0;
                     r_state   <= S_RESPAWN;
                     r_respawn <= 1'b1;
                  end
               end
            end
            S_RESPAWN: begin
               if (w_resp_done) begin
                  r_state   <= S_PLAY;
                  r_respawn <= 1'b0;
                  r_resp    <= '0;
                  r_hold    <= '0;
               end else begin
                  r_resp <= r_resp + RESP_ONE;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_respawn <= 1'b0;
               r_hold    <= '0;
               r_resp    <= '0;
            end
         endcase
      end
   end

   assign SC_COLLISION_HIT_OUT     = r_hit;
   assign SC_COLLISION_GOAL_OUT    = r_goal;
   assign SC_COLLISION_RESPAWN_OUT = r_respawn;
   assign SC_COLLISION_LIVES_OUT   = r_lives;
   assign SC_COLLISION_NVL_OUT     = r_nvl;
   assign SC_COLLISION_ESTADO_OUT  = DATAWIDTH_ESTADO'(r_state);

endmodule

// File: tb/tb_sc_collision_lives.sv
// -----------------------------------------------------------------------------
// tb_sc_collision_lives
// Scoreboard bench: a driver applies directed then random stimulus and, for
// every clock, pushes the expected registered outputs computed by a
// rule-level game model; a monitor pops and compares after each rising edge.
// -----------------------------------------------------------------------------
module tb_sc_collision_lives;

   localparam int HIT_HOLD   = 2;
   localparam int RESP_CYC   = 16;
   localparam int LIVES_INIT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] lane [4];
   logic [2:0] row;
   logic [2:0] col;

   logic       hit_o;
   logic       goal_o;
   logic       resp_o;
   logic [1:0] lives_o;
   logic [1:0] nvl_o;
   logic [2:0] estado_o;

   always #10 clk = ~clk;

   sc_collision_lives dut (
      .SC_COLLISION_CLOCK_50    (clk),
      .SC_COLLISION_RESET       (rst),
      .SC_COLLISION_START_IN    (start),
      .SC_COLLISION_LANE0_IN    (lane[0]),
      .SC_COLLISION_LANE1_IN    (lane[1]),
      .SC_COLLISION_LANE2_IN    (lane[2]),
      .SC_COLLISION_LANE3_IN    (lane[3]),
      .SC_COLLISION_FROG_ROW_IN (row),
      .SC_COLLISION_FROG_COL_IN (col),
      .SC_COLLISION_HIT_OUT     (hit_o),
      .SC_COLLISION_GOAL_OUT    (goal_o),
      .SC_COLLISION_RESPAWN_OUT (resp_o),
      .SC_COLLISION_LIVES_OUT   (lives_o),
      .SC_COLLISION_NVL_OUT     (nvl_o),
      .SC_COLLISION_ESTADO_OUT  (estado_o)
   );

   typedef struct packed {
      logic       hit;
      logic       goal;
      logic       resp;
      logic [1:0] lives;
      logic [1:0] nvl;
      logic [2:0] estado;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Rule-level game model: mode uses the published state codes
   int m_mode   = 0;   // 0 idle, 1 play, 2 respawn, 3 game over
   int m_streak = 0;   // consecutive overlapped cycles seen in play
   int m_left   = 0;   // respawn cycles still to run
   int m_lives  = 0;
   int m_level  = 0;

   task automatic model_step();
      bit   ov;
      bit   p_hit  = 1'b0;
      bit   p_goal = 1'b0;
      obs_t e;
      ov = (row >= 3'd1 && row <= 3'd4) ? lane[int'(row) - 1][col] : 1'b0;
      if (rst) begin
         m_mode = 0; m_streak = 0; m_left = 0; m_lives = 0; m_level = 0;
      end else if (m_mode == 0 || m_mode == 3) begin
         if (start) begin
            m_mode = 1; m_lives = LIVES_INIT; m_level = 0; m_streak = 0;
         end
      end else if (m_mode == 1) begin
         if (ov) begin
            if (m_streak + 1 >= HIT_HOLD) begin
               p_hit = 1'b1;
               m_lives = m_lives - 1;
               m_streak = 0;
               m_mode = (m_lives == 0) ? 3 : 2;
               m_left = RESP_CYC;
            end else begin
               m_streak++;
            end
         end else begin
            m_streak = 0;
            if (row == 3'd5) begin
               p_goal = 1'b1;
               if (m_level < 3) m_level++;
               m_mode = 2;
               m_left = RESP_CYC;
            end
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_mode = 1; m_streak = 0;
         end
      end
      e.hit    = p_hit;
      e.goal   = p_goal;
      e.resp   = (m_mode == 2);
      e.lives  = 2'(m_lives);
      e.nvl    = 2'(m_level);
      e.estado = 3'(m_mode);
      exp_q.push_back(e);
   endtask

   // Driver side: predict for the current inputs, then let one edge pass
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(negedge clk);
      end
   endtask

   obs_t mon_exp;
   obs_t mon_act;

   // Monitor: compare DUT outputs shortly after each rising edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {hit_o, goal_o, resp_o, lives_o, nvl_o, estado_o};
         n_cmp++;
         if (mon_act !== mon_exp) begin
            n_bad++;
            $display("FAIL outputs t=%0t got hit=%b goal=%b resp=%b lives=%0d nvl=%0d estado=%0d want hit=%b goal=%b resp=%b lives=%0d nvl=%0d estado=%0d",
                     $time, mon_act.hit, mon_act.goal, mon_act.resp, mon_act.lives, mon_act.nvl, mon_act.estado,
                     mon_exp.hit, mon_exp.goal, mon_exp.resp, mon_exp.lives, mon_exp.nvl, mon_exp.estado);
         end
      end
   end

   task automatic clear_lanes();
      for (int i = 0; i < 4; i++) lane[i] = 8'h00;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; row = 3'd0; col = 3'd0;
      clear_lanes();
      tick(2);
      rst = 1'b0;
      tick(2);

      // Reset and start
      start = 1'b1; tick(1); start = 1'b0; tick(2);

      // Debounce: one-cycle glitch, then a sustained overlap
      row = 3'd1; col = 3'd2;
      lane[0] = 8'h04; tick(1); lane[0] = 8'h00; tick(3);
      lane[0] = 8'h04; tick(2); lane[0] = 8'h00; tick(20);

      // Game over: remaining lives knocked out, then ignored overlap, restart
      for (int k = 0; k < 2; k++) begin
         lane[0] = 8'h04; tick(2); lane[0] = 8'h00; tick(20);
      end
      lane[0] = 8'h04; tick(4); lane[0] = 8'h00;
      start = 1'b1; tick(1); start = 1'b0; tick(1);

      // Goals with level saturation
      for (int k = 0; k < 5; k++) begin
         row = 3'd5; tick(1); row = 3'd0; tick(18);
      end

      // Safe rows under full traffic
      for (int i = 0; i < 4; i++) lane[i] = 8'hFF;
      row = 3'd0; tick(7); row = 3'd6; tick(7); row = 3'd7; tick(6);
      clear_lanes();

      // Reset mid-respawn, then overlap without start
      row = 3'd1; col = 3'd2;
      lane[0] = 8'h04; tick(2); lane[0] = 8'h00; tick(5);
      rst = 1'b1; tick(1); rst = 1'b0;
      lane[0] = 8'h04; tick(4); lane[0] = 8'h00;

      // Reset mid-hold
      start = 1'b1; tick(1); start = 1'b0;
      lane[0] = 8'h04; tick(1); rst = 1'b1; tick(1); rst = 1'b0; tick(3);
      lane[0] = 8'h00;

      // Random play
      start = 1'b1; tick(1); start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) row = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) col = 3'($urandom_range(0, 7));
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 2) == 0) lane[i] = 8'($urandom);
         end
         start = ($urandom_range(0, 39) == 0);
         rst   = ($urandom_range(0, 499) == 0);
         tick(1);
      end
      rst = 1'b0; start = 1'b0;

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
